booth_wallace_pipe: RTL and testbench
=====================================

// Module: booth_wallace_pipe
// PURPOSE
//  Parametrised, pipelined radix-4 Booth / Wallace-tree multiplier. Takes WxW operands with
//  a per-transaction signed/unsigned mode and returns the exact 2W-bit product.
//  Uses valid/ready handshakes on both sides and supports full throughput and backpressure.
//  Used as the streaming multiply engine for the datapath (MAC/filter front ends).
// PARAMETERS
//  W        8   operand width; even, >= 4
//  TAG_W    4   user tag width, carried alongside each operation unchanged
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_a       in   W      multiplicand
//  in_b       in   W      multiplier
//  in_signed  in   1      1: two's-complement operands; 0: unsigned operands
//  in_tag     in   TAG_W  user tag
//  out_valid  out  1      product valid
//  out_ready  in   1      consumer accepts product this cycle
//  out_p      out  2W     exact product
//  out_tag    out  TAG_W  tag of that product
// BEHAVIOUR
//  - Transfer occurs on a clk edge where valid && ready. in_* are sampled only on transfer.
//  - Three register stages, each holding a valid bit:
//    - S1 (capture): extend a and b to W+2 bits. Signed mode uses sign extension; unsigned
//      mode uses zero extension. Register them with the tag.
//    - S2 (recode + reduce): radix-4 Booth recode of {b_ext,1'b0} into NG = W/2+1 digits
//      {0,+-1,+-2}. Each partial product is sign-extended to 2W+2 bits and shifted by 2*i.
//      A 3:2 CSA tree reduces them to a sum/carry pair, which is registered.
//    - S3 (resolve): CPA of sum + (carry<<1), truncated to 2W bits -> out_p.
//  - Latency: 3 cycles from accept to out_valid when there is no stall. Throughput is 1 per
//    cycle.
//  - Flow: stage k loads when it is empty or its content moves downstream in the same cycle
//    (bubble-collapsing).
//    - adv3 = !v3 || out_ready; adv2 = !v2 || (v3 ? out_ready : 1); likewise for S1.
//    - in_ready = !v1 || adv(S2 can take S1). It is combinational from out_ready; no
//      combinational path from in_valid.
//  - Stall: while out_valid && !out_ready, out_p and out_tag hold stable. Up to 3 beats
//    are buffered, after which in_ready = 0.
//  - Products leave in accept order. Tag and mode travel with their operands, so mixed
//    signed/unsigned beats back-to-back are legal.
//  - Width: the result is exact for all inputs.
//    - Signed range: [-2^(2W-2)+2^(W-1), 2^(2W-2)].
//    - Unsigned max: (2^W-1)^2. No overflow is possible.
//  - Reset (async assert, sync release):
//    - All valid bits are cleared. out_valid = 0 and in_ready = 1 from the first cycle
//      after release.
//    - out_p and out_tag reset to 0. Data registers in S1 and S2 need no reset.
//    - Reset mid-operation discards in-flight beats; no stale product appears after release.
//  - X on in_a or in_b while in_valid = 0 must not propagate to out_valid.
// TESTING
//  - W=8, signed:
//    - a=-128, b=-128 -> out_p=16'h4000 three cycles later.
//    - a=-1, b=1 -> 16'hFFFF.
//    - a=127, b=-128 -> 16'hC080.
//  - W=8, unsigned: a=255, b=255 -> 16'hFE01. Same operands with in_signed=1 -> 16'h0001.
//  - Streaming: 256 back-to-back random beats with mixed mode and out_ready=1 -> one
//    product per cycle after 3-cycle fill. Results in order, tags match, all equal the
//    reference model.
//  - Backpressure: hold out_ready=0 and offer 5 beats.
//    - Exactly 3 are accepted, then in_ready=0 and out_p is stable.
//    - Raising out_ready drains all 3 in order with no loss or duplication.
//  - Random out_ready (50%) and in_valid (50%) for 10k beats, W in {4,8,16}.
//    - Scoreboard exact match. in_valid/out_valid handshake rules hold: data is stable
//      while valid && !ready.
//  - Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and in_ready=1 after
//    release. No stale product is seen. The next beat, 3*5=15, returns 16'h000F.

Source files
------------

// File: rtl/booth_wallace_pipe_if.sv
// rtl/booth_wallace_pipe_if.sv - operand/product handshake bundle for the Booth/Wallace multiplier
interface booth_wallace_pipe_if #(
    parameter int W     = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_p;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );
endinterface

// File: rtl/booth_wallace_pipe.sv
// rtl/booth_wallace_pipe.sv - 3-stage radix-4 Booth / Wallace-tree multiplier with valid/ready flow
module booth_wallace_pipe #(
    parameter int W     = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_wallace_pipe_if.slave  bus
);
    localparam int EW = W + 2;
    localparam int PW = 2 * W + 2;
    localparam int NG = W / 2 + 1;
    localparam int NR = 3 * NG;

    logic             v1, v2, v3;
    logic             adv1, adv2, adv3;
    logic [EW-1:0]    a1, b1;
    logic [TAG_W-1:0] tag1, tag2;
    logic [PW-1:0]    sum2, carry2;
    logic [PW-1:0]    red_sum, red_carry;

    // Each stage may load when empty or when its content leaves in the same cycle.
    assign adv3          = !v3 || bus.out_ready;
    assign adv2          = !v2 || adv3;
    assign adv1          = !v1 || adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3;

    always_comb begin : reduce
        logic [PW-1:0] rows [NR];
        logic [PW-1:0] nxt  [NR];
        logic [PW-1:0] ax;
        logic [PW-1:0] pp;
        logic [EW:0]   bx;
        int            n;
        int            m;

        ax = {{(PW-EW){a1[EW-1]}}, a1};
        bx = {b1, 1'b0};
        pp = '0;
        n  = NG;
        m  = 0;
        for (int r = 0; r < NR; r++) begin
            rows[r] = '0;
            nxt[r]  = '0;
        end

        for (int i = 0; i < NG; i++) begin
            case (bx[2*i +: 3])
                3'b001, 3'b010: pp = ax;
                3'b011:         pp = ax << 1;
                3'b100:         pp = -(ax << 1);
                3'b101, 3'b110: pp = -ax;
                default:        pp = '0;
            endcase
            rows[i] = pp << (2 * i);
        end

        // Wallace levels: every full triple becomes a sum row and a pre-shifted carry row.
        for (int lvl = 0; lvl < NG; lvl++) begin
            if (n > 2) begin
                m = 0;
                for (int r = 0; r < NR; r++) nxt[r] = '0;
                for (int g = 0; g < NG; g++) begin
                    if (3*g + 2 < n) begin
                        nxt[m]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
                        nxt[m+1] = ((rows[3*g] & rows[3*g+1]) |
                                    (rows[3*g] & rows[3*g+2]) |
                                    (rows[3*g+1] & rows[3*g+2])) << 1;
                        m = m + 2;
                    end else if (3*g < n) begin
                        nxt[m] = rows[3*g];
                        m = m + 1;
                        if (3*g + 1 < n) begin
                            nxt[m] = rows[3*g+1];
                            m = m + 1;
                        end
                    end
                end
                for (int r = 0; r < NR; r++) rows[r] = nxt[r];
                n = m;
            end
        end

        red_sum   = rows[0];
        red_carry = rows[1] >> 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            bus.out_p   <= '0;
            bus.out_tag <= '0;
        end else begin
            if (adv1) v1 <= bus.in_valid;
            if (adv2) v2 <= v1;
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    bus.out_p   <= (2*W)'(sum2 + (carry2 << 1));
                    bus.out_tag <= tag2;
                end
            end
        end
    end

    // Operand and reduction registers are qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (bus.in_valid && adv1) begin
            a1   <= bus.in_signed ? {{2{bus.in_a[W-1]}}, bus.in_a} : {2'b00, bus.in_a};
            b1   <= bus.in_signed ? {{2{bus.in_b[W-1]}}, bus.in_b} : {2'b00, bus.in_b};
            tag1 <= bus.in_tag;
        end
        if (v1 && adv2) begin
            sum2   <= red_sum;
            carry2 <= red_carry;
            tag2   <= tag1;
        end
    end
endmodule

// File: tb/tb_booth_wallace_pipe.sv
// tb/tb_booth_wallace_pipe.sv - scoreboard bench for booth_wallace_pipe at W=8
module tb_booth_wallace_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_wallace_pipe_if #(.W(8), .TAG_W(4)) bus ();
    booth_wallace_pipe #(.W(8), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [15:0] p;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  tag_ctr = 4'd0;
    bit          rand_ready = 1'b0;
    bit          stall_prev = 1'b0;
    logic [15:0] hold_p;
    logic [3:0]  hold_tag;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa, sb;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return sa * sb;
        end
        return {8'd0, a} * {8'd0, b};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, output int waits);
        bit done = 1'b0;
        waits = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        bus.in_tag    = tag_ctr;
        while (!done && waits < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back({exp, tag_ctr});
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        tag_ctr++;
        bus.in_valid = 1'b0;
        bus.in_a     = 'x;
        bus.in_b     = 'x;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 want accept a=%h b=%h", a, b);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_cmp++;
                if (!bus.out_valid || bus.out_p !== hold_p || bus.out_tag !== hold_tag) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b p=%h tag=%h want v=1 p=%h tag=%h",
                             bus.out_valid, bus.out_p, bus.out_tag, hold_p, hold_tag);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got p=%h tag=%h want no product", bus.out_p, bus.out_tag);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (bus.out_p !== e.p || bus.out_tag !== e.tag) begin
                        n_err++;
                        $display("FAIL product: got p=%h tag=%h want p=%h tag=%h",
                                 bus.out_p, bus.out_tag, e.p, e.tag);
                    end
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            hold_p     = bus.out_p;
            hold_tag   = bus.out_tag;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    vec_t dir_v[14] = '{
        '{8'h80, 8'h80, 1'b1, 16'h4000},
        '{8'hFF, 8'h01, 1'b1, 16'hFFFF},
        '{8'h7F, 8'h80, 1'b1, 16'hC080},
        '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
        '{8'hFF, 8'hFF, 1'b1, 16'h0001},
        '{8'h00, 8'h9A, 1'b1, 16'h0000},
        '{8'h80, 8'h02, 1'b0, 16'h0100},
        '{8'h80, 8'h02, 1'b1, 16'hFF00},
        '{8'hC8, 8'h64, 1'b0, 16'h4E20},
        '{8'hFE, 8'hFD, 1'b1, 16'h0006},
        '{8'h7F, 8'h7F, 1'b1, 16'h3F01},
        '{8'h80, 8'h80, 1'b0, 16'h4000},
        '{8'h01, 8'hFF, 1'b0, 16'h00FF},
        '{8'h80, 8'h7F, 1'b1, 16'hC080}
    };

    vec_t bp_v[5] = '{
        '{8'h80, 8'h80, 1'b1, 16'h4000},
        '{8'h0C, 8'h0D, 1'b0, 16'h009C},
        '{8'hFE, 8'h03, 1'b1, 16'hFFFA},
        '{8'hFF, 8'h02, 1'b0, 16'h01FE},
        '{8'h7F, 8'h7F, 1'b1, 16'h3F01}
    };

    initial begin
        int w;
        int stalls;
        int lat;
        int acc;
        logic [7:0] ra, rb;
        logic       rs;

        bus.in_valid  = 1'b0;
        bus.in_a      = 'x;
        bus.in_b      = 'x;
        bus.in_signed = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_p", bus.out_p, 0);
        check("rst_out_tag", bus.out_tag, 0);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        send(dir_v[0].a, dir_v[0].b, dir_v[0].s, dir_v[0].p, w);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            @(posedge clk);
            #1;
        end while (lat < 10);
        check("latency", lat, 3);
        @(posedge clk);
        #1;

        for (int i = 1; i < 14; i++) send(dir_v[i].a, dir_v[i].b, dir_v[i].s, dir_v[i].p, w);
        drain();

        // Backpressure: 5 beats offered into a stalled output.
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            if (acc < 5) begin
                bus.in_valid  = 1'b1;
                bus.in_a      = bp_v[acc].a;
                bus.in_b      = bp_v[acc].b;
                bus.in_signed = bp_v[acc].s;
                bus.in_tag    = tag_ctr;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back({bp_v[acc].p, tag_ctr});
                tag_ctr++;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", acc, 3);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_out_p", bus.out_p, 32'h4000);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 3; i < 5; i++) send(bp_v[i].a, bp_v[i].b, bp_v[i].s, bp_v[i].p, w);
        drain();

        stalls = 0;
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs), w);
            stalls += w;
        end
        check("stream_no_stall", stalls, 0);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs), w);
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset with three beats in flight; none may come out afterwards.
        send(8'd10, 8'd10, 1'b0, 16'd100, w);
        send(8'd20, 8'd3, 1'b0, 16'd60, w);
        send(8'hFF, 8'h02, 1'b1, 16'hFFFE, w);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", bus.out_valid, 0);
        check("rst2_in_ready", bus.in_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        send(8'd3, 8'd5, 1'b0, 16'h000F, w);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
